// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: requester-side controller for the 64-bit multi-cycle divider.
// Buffers divide micro-ops in order and launches them one at a time on the
// divider's valid/ready port. Divide-by-zero and signed overflow are answered
// locally without using the divider. Quotients are broadcast on the CDB under
// a grant handshake. A flush discards buffered work and drains any divide that
// is still in flight.
module div_issue_ctrl #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic             issue_signed,
    input  logic [63:0]      issue_dividend,
    input  logic [63:0]      issue_divisor,
    output logic             div_valid_in,
    input  logic             div_ready,
    output logic             div_signed,
    output logic [63:0]      div_dividend,
    output logic [63:0]      div_divisor,
    input  logic             div_valid_out,
    input  logic [63:0]      div_quotient,
    output logic             div_yumi,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [63:0]      cdb_data,
    input  logic             cdb_grant
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] INT_MIN  = 64'h8000_0000_0000_0000;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             sgn;
        logic [63:0]      dividend;
        logic [63:0]      divisor;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    // request buffer storage and pointers
    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    // control state, held operands and result register
    state_t           state_reg;
    entry_t           op_reg;
    logic             res_valid_reg;
    logic [TAG_W-1:0] res_tag_reg;
    logic [63:0]      res_data_reg;

    entry_t head;
    logic   fifo_empty;
    logic   fifo_full;
    logic   push;
    logic   pop;
    logic   head_div_zero;
    logic   head_overflow;
    logic   res_consume;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign fifo_empty  = (count_reg == '0);
    assign fifo_full   = (count_reg == CNT_W'(DEPTH));
    assign issue_ready = ~fifo_full & ~flush;
    assign push        = issue_valid & issue_ready;
    assign head        = mem[rd_ptr_reg];

    // Only one op leaves the buffer at a time, and only into an empty result
    // register, which keeps CDB order identical to issue order.
    assign pop = (state_reg == IDLE) & ~fifo_empty & ~res_valid_reg & ~flush;

    assign head_div_zero = (head.divisor == '0);
    assign head_overflow = head.sgn & (head.dividend == INT_MIN) & (head.divisor == ALL_ONES);

    // A real result is only captured outside a flush; during a flush it is dropped.
    assign res_consume = (state_reg == BUSY) & div_valid_out & ~res_valid_reg & ~flush;

    assign div_valid_in = (state_reg == LAUNCH);
    assign div_signed   = op_reg.sgn;
    assign div_dividend = op_reg.dividend;
    assign div_divisor  = op_reg.divisor;

    assign cdb_valid = res_valid_reg;
    assign cdb_tag   = res_tag_reg;
    assign cdb_data  = res_data_reg;

    // Result acknowledge: consume into the result register, or discard when flushed.
    always_comb begin
        div_yumi = 1'b0;
        case (state_reg)
            // A result arriving in the flush cycle is discarded right away so
            // that DRAIN never waits for a result that has already gone.
            BUSY:    div_yumi = div_valid_out & (flush | ~res_valid_reg);
            DRAIN:   div_yumi = div_valid_out;
            default: div_yumi = 1'b0;
        endcase
    end

    // Buffer storage write; entries need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {issue_tag, issue_signed, issue_dividend, issue_divisor};
        end
    end

    // Buffer pointers and occupancy; a flush empties the buffer.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Launch FSM with the op register and the CDB result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            op_reg        <= '0;
            res_valid_reg <= 1'b0;
            res_tag_reg   <= '0;
            res_data_reg  <= '0;
        end else begin
            if (flush) begin
                res_valid_reg <= 1'b0;
            end else if (res_valid_reg && cdb_grant) begin
                res_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        if (head_div_zero) begin
                            res_valid_reg <= 1'b1;
                            res_tag_reg   <= head.tag;
                            res_data_reg  <= ALL_ONES;
                        end else if (head_overflow) begin
                            res_valid_reg <= 1'b1;
                            res_tag_reg   <= head.tag;
                            res_data_reg  <= head.dividend;
                        end else begin
                            // op_reg is only reloaded here, so the divider sees
                            // stable operands for the whole operation.
                            op_reg    <= head;
                            state_reg <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    if (flush) begin
                        // If the divider takes the op in the flush cycle its
                        // result must still be drained.
                        state_reg <= div_ready ? DRAIN : IDLE;
                    end else if (div_ready) begin
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state_reg <= div_valid_out ? IDLE : DRAIN;
                    end else if (res_consume) begin
                        res_valid_reg <= 1'b1;
                        res_tag_reg   <= op_reg.tag;
                        res_data_reg  <= div_quotient;
                        state_reg     <= IDLE;
                    end
                end
                DRAIN: begin
                    if (div_valid_out) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Testbench for div_issue_ctrl: a behavioural divider with fixed latency,
// a table of single-op vectors and hand-written multi-cycle sequences.
module tb_div_issue_ctrl;

    localparam int DEPTH = 2;
    localparam int TAG_W = 6;
    localparam int LAT   = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             issue_valid;
    logic             issue_ready;
    logic [TAG_W-1:0] issue_tag;
    logic             issue_signed;
    logic [63:0]      issue_dividend;
    logic [63:0]      issue_divisor;
    logic             div_valid_in;
    logic             div_ready;
    logic             div_signed;
    logic [63:0]      div_dividend;
    logic [63:0]      div_divisor;
    logic             div_valid_out;
    logic [63:0]      div_quotient;
    logic             div_yumi;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [63:0]      cdb_data;
    logic             cdb_grant;

    always #5 clk = ~clk;

    div_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_tag      (issue_tag),
        .issue_signed   (issue_signed),
        .issue_dividend (issue_dividend),
        .issue_divisor  (issue_divisor),
        .div_valid_in   (div_valid_in),
        .div_ready      (div_ready),
        .div_signed     (div_signed),
        .div_dividend   (div_dividend),
        .div_divisor    (div_divisor),
        .div_valid_out  (div_valid_out),
        .div_quotient   (div_quotient),
        .div_yumi       (div_yumi),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .cdb_grant      (cdb_grant)
    );

    // ---------------- behavioural divider ----------------
    logic        dv_busy;
    int          dv_cnt;
    logic [63:0] dv_q;
    logic [63:0] dv_dvd;
    logic [63:0] dv_dvs;
    logic        dv_sgn;

    function automatic logic [63:0] quot(input logic s, input logic [63:0] a, input logic [63:0] b);
        if (b == 64'd0) return 64'hFFFF_FFFF_FFFF_FFFF;
        if (s) return 64'($signed(a) / $signed(b));
        return a / b;
    endfunction

    assign div_ready     = ~dv_busy;
    assign div_valid_out = dv_busy && (dv_cnt == 0);
    assign div_quotient  = dv_q;

    always @(posedge clk) begin
        if (reset) begin
            dv_busy <= 1'b0;
            dv_cnt  <= 0;
        end else if (!dv_busy) begin
            if (div_valid_in) begin
                dv_busy <= 1'b1;
                dv_cnt  <= LAT;
                dv_dvd  <= div_dividend;
                dv_dvs  <= div_divisor;
                dv_sgn  <= div_signed;
                dv_q    <= quot(div_signed, div_dividend, div_divisor);
            end
        end else if (dv_cnt != 0) begin
            dv_cnt <= dv_cnt - 1;
        end else if (div_yumi) begin
            dv_busy <= 1'b0;
        end
    end

    // ---------------- bench state ----------------
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic             sgn;
        logic [63:0]      dvd;
        logic [63:0]      dvs;
    } op_t;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [63:0]      data;
    } res_t;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic             sgn;
        logic [63:0]      dvd;
        logic [63:0]      dvs;
        logic [63:0]      exp;
        logic             byp;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    op_t  pend[$];
    res_t got[$];
    int   n_acc, n_launch, n_yumi, n_cdbv;
    int   last_acc, first_launch, first_cdb, dvo_cyc;
    logic last_ready;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        n_acc = 0; n_launch = 0; n_yumi = 0; n_cdbv = 0;
        last_acc = -1; first_launch = -1; first_cdb = -1; dvo_cyc = -1;
        got.delete();
    endtask

    task automatic push_op(input logic [TAG_W-1:0] t, input logic s,
                           input logic [63:0] a, input logic [63:0] b);
        op_t o;
        o.tag = t; o.sgn = s; o.dvd = a; o.dvs = b;
        pend.push_back(o);
    endtask

    // One clock: drive the pending op, sample just before the rising edge,
    // then return on the falling edge.
    task automatic step();
        res_t r;
        if (pend.size() > 0) begin
            issue_valid    = 1'b1;
            issue_tag      = pend[0].tag;
            issue_signed   = pend[0].sgn;
            issue_dividend = pend[0].dvd;
            issue_divisor  = pend[0].dvs;
        end else begin
            issue_valid = 1'b0;
        end
        #2;
        last_ready = issue_ready;
        if (dv_busy === 1'b1) begin
            chk("op_stable_sgn", 64'(div_signed), 64'(dv_sgn));
            chk("op_stable_dvd", div_dividend, dv_dvd);
            chk("op_stable_dvs", div_divisor, dv_dvs);
        end
        if (issue_valid && issue_ready) begin
            n_acc++;
            last_acc = cyc;
            void'(pend.pop_front());
        end
        if (div_valid_in && first_launch < 0) first_launch = cyc;
        if (div_valid_in && div_ready) n_launch++;
        if (div_valid_out && div_yumi) begin
            dvo_cyc = cyc;
            n_yumi++;
        end
        if (cdb_valid) begin
            n_cdbv++;
            if (first_cdb < 0) first_cdb = cyc;
        end
        if (cdb_valid && cdb_grant) begin
            r.tag  = cdb_tag;
            r.data = cdb_data;
            got.push_back(r);
            $display("cdb: cycle=%0d tag=%0d data=%h", cyc, cdb_tag, cdb_data);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_results(input int n, input int budget);
        int k;
        k = 0;
        while (got.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("results_in_time", 64'(got.size()), 64'(n));
    endtask

    task automatic wait_launch(input int budget);
        int k;
        k = 0;
        while (n_launch == 0 && k < budget) begin
            step();
            k++;
        end
        chk("launch_in_time", 64'(n_launch), 64'd1);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; cdb_grant = 1'b1;
        issue_valid = 1'b0; issue_tag = '0; issue_signed = 1'b0;
        issue_dividend = '0; issue_divisor = '0;
        clear_stats();

        // single-op vectors: {tag, signed, dividend, divisor, quotient, bypass}
        vecs[0] = '{6'd3, 1'b0, 64'd50, 64'd5, 64'd10, 1'b0};
        vecs[1] = '{6'd4, 1'b1, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[2] = '{6'd5, 1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[3] = '{6'd6, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'h8000_0000_0000_0000, 1'b1};
        vecs[4] = '{6'd7, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0};
        vecs[5] = '{6'd8, 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0};

        repeat (2) step();
        reset = 1'b0;

        // reset state
        chk("rst_div_valid_in", 64'(div_valid_in), 64'd0);
        chk("rst_div_yumi", 64'(div_yumi), 64'd0);
        chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("rst_issue_ready", 64'(issue_ready), 64'd1);

        // table: one op at a time, grant tied high
        for (int i = 0; i < 6; i++) begin
            clear_stats();
            push_op(vecs[i].tag, vecs[i].sgn, vecs[i].dvd, vecs[i].dvs);
            wait_results(1, 40);
            repeat (3) step();
            if (got.size() > 0) begin
                chk("vec_tag", 64'(got[0].tag), 64'(vecs[i].tag));
                chk("vec_data", got[0].data, vecs[i].exp);
            end
            chk("vec_cdb_cycles", 64'(n_cdbv), 64'd1);
            if (vecs[i].byp) begin
                chk("byp_no_launch", 64'(first_launch), 64'hFFFF_FFFF_FFFF_FFFF);
                chk("byp_latency", 64'(first_cdb - last_acc), 64'd2);
            end else begin
                chk("div_launch_latency", 64'(first_launch - last_acc), 64'd2);
                chk("div_cdb_after_yumi", 64'(first_cdb - dvo_cyc), 64'd1);
                chk("div_launch_count", 64'(n_launch), 64'd1);
            end
        end

        // signed back-to-back, order and tags preserved
        clear_stats();
        push_op(6'd10, 1'b1, 64'hFFFF_FFFF_FFFF_FFCE, 64'd5);
        push_op(6'd11, 1'b1, 64'd50, 64'hFFFF_FFFF_FFFF_FFFB);
        wait_results(2, 60);
        if (got.size() >= 2) begin
            chk("b2b_tag0", 64'(got[0].tag), 64'd10);
            chk("b2b_data0", got[0].data, 64'hFFFF_FFFF_FFFF_FFF6);
            chk("b2b_tag1", 64'(got[1].tag), 64'd11);
            chk("b2b_data1", got[1].data, 64'hFFFF_FFFF_FFFF_FFF6);
        end
        chk("b2b_launches", 64'(n_launch), 64'd2);

        // flush clears a pending result register
        clear_stats();
        cdb_grant = 1'b0;
        push_op(6'd19, 1'b0, 64'd7, 64'd0);
        repeat (4) step();
        chk("hold_byp_valid", 64'(cdb_valid), 64'd1);
        chk("hold_byp_tag", 64'(cdb_tag), 64'd19);
        chk("hold_byp_data", cdb_data, 64'hFFFF_FFFF_FFFF_FFFF);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_res_ready", 64'(last_ready), 64'd0);
        chk("flush_cdb_clear", 64'(cdb_valid), 64'd0);
        cdb_grant = 1'b1;
        repeat (3) step();
        chk("flush_res_no_cdb", 64'(got.size()), 64'd0);

        // flush while BUSY: drain the divider, then a new divide works
        clear_stats();
        push_op(6'd20, 1'b0, 64'd100, 64'd7);
        wait_launch(10);
        step();
        flush = 1'b1;
        push_op(6'd22, 1'b0, 64'd9, 64'd3);
        step();
        flush = 1'b0;
        pend.delete();
        chk("flush_busy_ready", 64'(last_ready), 64'd0);
        push_op(6'd21, 1'b0, 64'd100, 64'd4);
        wait_results(1, 60);
        repeat (3) step();
        chk("flush_only_new", 64'(got.size()), 64'd1);
        if (got.size() > 0) begin
            chk("after_flush_tag", 64'(got[0].tag), 64'd21);
            chk("after_flush_data", got[0].data, 64'd25);
        end
        chk("flush_yumis", 64'(n_yumi), 64'd2);
        chk("flush_launches", 64'(n_launch), 64'd2);

        // grant held low while the buffer fills
        clear_stats();
        cdb_grant = 1'b0;
        push_op(6'd30, 1'b0, 64'd90, 64'd9);
        push_op(6'd31, 1'b0, 64'd81, 64'd9);
        push_op(6'd32, 1'b0, 64'd64, 64'd8);
        push_op(6'd33, 1'b0, 64'd49, 64'd7);
        repeat (12) step();
        chk("full_accepts", 64'(n_acc), 64'(DEPTH + 1));
        chk("full_issue_ready", 64'(issue_ready), 64'd0);
        chk("full_one_launch", 64'(n_launch), 64'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_valid", 64'(cdb_valid), 64'd1);
            chk("stall_tag", 64'(cdb_tag), 64'd30);
            chk("stall_data", cdb_data, 64'd10);
            chk("stall_no_launch", 64'(div_valid_in), 64'd0);
        end
        cdb_grant = 1'b1;
        wait_results(4, 80);
        if (got.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("drain_tag", 64'(got[k].tag), 64'(30 + k));
                chk("drain_data", got[k].data, 64'(10 - k));
            end
        end

        // reset in the middle of a divide
        clear_stats();
        push_op(6'd40, 1'b0, 64'd100, 64'd3);
        wait_launch(10);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_div_valid_in", 64'(div_valid_in), 64'd0);
        chk("midrst_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("midrst_issue_ready", 64'(issue_ready), 64'd1);
        repeat (8) step();
        chk("midrst_no_result", 64'(got.size()), 64'd0);
        push_op(6'd41, 1'b0, 64'd100, 64'd3);
        wait_results(1, 40);
        if (got.size() > 0) begin
            chk("postrst_tag", 64'(got[0].tag), 64'd41);
            chk("postrst_data", got[0].data, 64'd33);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
